fmul_issue_arb: RTL and testbench

- Shares one pipelined fmul unit between two requesters, e.g. the two issue slots of the FP execute stage.
- Arbitrates operand issue round-robin and carries each operation's dest-register tag (add) and flag through fmul's passthrough lanes.
- Tracks which requester owns each in-flight slot and steers every result into that requester's result FIFO.
- Uses credit-based issue, so results are never dropped while fmul itself never stalls.

---
 rtl/fmul_issue_arb.sv | 166 ++++++++++++++++
 tb/tb_fmul_issue_arb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_issue_arb.sv
// Two-requester front end for a shared fixed-latency fmul: round-robin issue,
// tag/owner tracking through the pipe, and credit-protected per-requester result FIFOs.
module fmul_issue_arb_fifo #(
  parameter  int DW    = 38,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [CW-1:0] cnt,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_pop;

  assign do_pop = pop && (cnt != '0);
  assign dout   = mem[rp];

  always_ff @(posedge clk)
    if (push) mem[wp] <= din;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push)   wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module fmul_issue_arb #(
  parameter int LAT    = 2,
  parameter int FDEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_x1,
  input  logic [63:0] req_x2,
  input  logic [9:0]  req_add,
  input  logic [1:0]  req_flag,
  output logic [1:0]  res_valid,
  input  logic [1:0]  res_ready,
  output logic [63:0] res_y,
  output logic [9:0]  res_add,
  output logic [1:0]  res_flag,
  output logic [31:0] fm_x1,
  output logic [31:0] fm_x2,
  output logic        fm_flagin,
  output logic [4:0]  fm_addin,
  input  logic [31:0] fm_y,
  input  logic        fm_flagout,
  input  logic [4:0]  fm_addout,
  output logic        busy
);
  localparam int NREQ = 2;
  localparam int CW   = $clog2(FDEPTH + 1);

  typedef struct packed {
    logic [31:0] y;
    logic        flag;
    logic [4:0]  add;
  } res_t;

  logic [NREQ-1:0][31:0]   x1_v, x2_v, y_v;
  logic [NREQ-1:0][4:0]    add_v, radd_v;
  logic [NREQ-1:0][CW-1:0] fifo_cnt, inflight;
  logic [NREQ-1:0]         elig, grant, push;
  res_t [NREQ-1:0]         head;
  res_t                    push_data;
  logic                    prio, g, grant_any;
  logic [LAT-1:0]          vld_pipe, id_pipe;

  assign x1_v  = req_x1;
  assign x2_v  = req_x2;
  assign add_v = req_add;

  // With a single eligible requester, elig[1] alone names it.
  always_comb begin
    grant_any = |elig;
    g         = (&elig) ? prio : elig[1];
    grant     = '0;
    if (grant_any) grant[g] = 1'b1;
  end

  assign req_ready = grant;
  assign fm_x1     = grant_any ? x1_v[g]  : '0;
  assign fm_x2     = grant_any ? x2_v[g]  : '0;
  assign fm_addin  = grant_any ? add_v[g] : '0;
  assign fm_flagin = grant_any & req_flag[g];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          prio <= 1'b0;
    else if (grant_any) prio <= ~g;
  end

  // Owner tag rides alongside fmul; the last stage lines up with fm_y.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= grant_any;
      id_pipe[0]  <= g;
      for (int s = 1; s < LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  assign push_data = {fm_y, fm_flagout, fm_addout};

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    logic [CW:0]   used;
    logic [CW-1:0] infl_q;

    // Slots already promised to buffered or in-flight results are not re-issued.
    assign used     = {1'b0, fifo_cnt[i]} + {1'b0, infl_q};
    assign elig[i]  = rstn && req_valid[i] && (used < (CW+1)'(FDEPTH));
    assign push[i]  = vld_pipe[LAT-1] && (id_pipe[LAT-1] == 1'(i));
    assign inflight[i] = infl_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) infl_q <= '0;
      else case ({grant[i], push[i]})
        2'b10:   infl_q <= infl_q + CW'(1);
        2'b01:   infl_q <= infl_q - CW'(1);
        default: ;
      endcase
    end

    fmul_issue_arb_fifo #(.DW($bits(res_t)), .DEPTH(FDEPTH)) u_fifo (
      .clk  (clk),
      .rstn (rstn),
      .push (push[i]),
      .din  (push_data),
      .pop  (res_ready[i]),
      .cnt  (fifo_cnt[i]),
      .dout (head[i])
    );

    assign res_valid[i] = fifo_cnt[i] != '0;
    assign y_v[i]       = res_valid[i] ? head[i].y   : '0;
    assign radd_v[i]    = res_valid[i] ? head[i].add : '0;
    assign res_flag[i]  = res_valid[i] & head[i].flag;
  end

  assign res_y   = y_v;
  assign res_add = radd_v;
  assign busy    = |{fifo_cnt, inflight};
endmodule

// File: tb/tb_fmul_issue_arb.sv
// Randomised bench for fmul_issue_arb: a small float-multiply pipe stands in for fmul,
// and a queue-based scoreboard predicts grants, result streams and busy every cycle.
module tb_fmul_issue_arb;
  localparam int LAT    = 2;
  localparam int FDEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid, req_ready, req_flag, res_valid, res_ready, res_flag;
  logic [63:0] req_x1, req_x2, res_y;
  logic [9:0]  req_add, res_add;
  logic [31:0] fm_x1, fm_x2, fm_y;
  logic        fm_flagin, fm_flagout, busy;
  logic [4:0]  fm_addin, fm_addout;

  fmul_issue_arb #(.LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_add(req_add), .req_flag(req_flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_add(res_add), .res_flag(res_flag),
    .fm_x1(fm_x1), .fm_x2(fm_x2), .fm_flagin(fm_flagin), .fm_addin(fm_addin),
    .fm_y(fm_y), .fm_flagout(fm_flagout), .fm_addout(fm_addout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Normal single-precision operands only; routed through double-precision reals.
  function automatic logic [63:0] f2d(input logic [31:0] a);
    logic [10:0] e;
    e = {3'b000, a[30:23]} + 11'd896;
    return {a[31], e, a[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [10:0] e;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul_f(input logic [31:0] a, input logic [31:0] b);
    real p;
    p = $bitstoreal(f2d(a)) * $bitstoreal(f2d(b));
    return d2f($realtobits(p));
  endfunction

  // Stand-in fmul: fixed LAT=2, no reset, no stall.
  logic [37:0] fp1 = '0, fp2 = '0;
  always @(posedge clk) begin
    fp1 <= {fmul_f(fm_x1, fm_x2), fm_flagin, fm_addin};
    fp2 <= fp1;
  end
  assign {fm_y, fm_flagout, fm_addout} = fp2;

  typedef struct packed {
    logic [31:0] y;
    logic        flag;
    logic [4:0]  add;
  } rec_t;

  typedef struct {
    int   due;
    int   id;
    rec_t r;
  } fl_t;

  rec_t mq0[$], mq1[$];
  fl_t  flight[$];
  logic prio_m;
  int   cyc, n_chk, n_pass;
  int   gcnt[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    flight.delete();
    prio_m = 1'b0;
  endtask

  // Called mid-cycle once inputs are settled: check, then advance the model by one edge.
  task automatic model_cycle();
    int   cnt[2], infl[2], gg;
    logic [1:0] el, exp_rdy;
    logic [31:0] ex1, ex2;
    logic [4:0]  ea;
    logic        ef;
    rec_t        hd;
    fl_t         f;

    cnt[0] = mq0.size();
    cnt[1] = mq1.size();
    infl[0] = 0;
    infl[1] = 0;
    foreach (flight[j]) infl[flight[j].id]++;
    for (int i = 0; i < 2; i++)
      el[i] = req_valid[i] && (FDEPTH - cnt[i] - infl[i] > 0);

    if (el == 2'b11)   gg = int'(prio_m);
    else if (el[0])    gg = 0;
    else if (el[1])    gg = 1;
    else               gg = -1;

    exp_rdy = '0;
    ex1 = '0; ex2 = '0; ea = '0; ef = 1'b0;
    if (gg >= 0) begin
      exp_rdy[gg] = 1'b1;
      ex1 = req_x1[32*gg +: 32];
      ex2 = req_x2[32*gg +: 32];
      ea  = req_add[5*gg +: 5];
      ef  = req_flag[gg];
    end

    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("fm_ops", {fm_x1, fm_x2}, {ex1, ex2});
    chk("fm_tag", 64'({fm_flagin, fm_addin}), 64'({ef, ea}));
    chk("res_valid", 64'(res_valid), 64'({cnt[1] != 0, cnt[0] != 0}));
    hd = (cnt[0] != 0) ? mq0[0] : '0;
    chk("res0", 64'({res_y[31:0], res_flag[0], res_add[4:0]}), 64'(hd));
    hd = (cnt[1] != 0) ? mq1[0] : '0;
    chk("res1", 64'({res_y[63:32], res_flag[1], res_add[9:5]}), 64'(hd));
    chk("busy", 64'(busy), 64'((cnt[0] + cnt[1] + infl[0] + infl[1]) != 0));

    if (gg >= 0) begin
      f.due = cyc + LAT;
      f.id  = gg;
      f.r   = '{y: fmul_f(ex1, ex2), flag: ef, add: ea};
      flight.push_back(f);
      prio_m = (gg == 0);
      gcnt[gg]++;
    end
    if (res_ready[0] && mq0.size() != 0) void'(mq0.pop_front());
    if (res_ready[1] && mq1.size() != 0) void'(mq1.pop_front());
    while (flight.size() != 0 && flight[0].due == cyc) begin
      f = flight.pop_front();
      if (f.id == 0) mq0.push_back(f.r);
      else           mq1.push_back(f.r);
    end
    cyc++;
  endtask

  task automatic step();
    #1;
    model_cycle();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  task automatic rand_ops();
    req_x1   = {rnd_f(), rnd_f()};
    req_x2   = {rnd_f(), rnd_f()};
    req_add  = 10'($urandom);
    req_flag = 2'($urandom);
  endtask

  task automatic idle(input int n);
    req_valid = 2'b00;
    res_ready = 2'b11;
    repeat (n) step();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    gcnt[0] = 0; gcnt[1] = 0;
    rstn = 1'b0;
    req_valid = 2'b11; res_ready = 2'b00;
    rand_ops();
    model_reset();

    // Reset state, with requests pending.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_res", 64'({res_valid, busy, res_flag}), 64'd0);
    chk("rst_fm", {fm_x1, fm_x2}, 64'd0);
    chk("rst_y", res_y, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Single op on requester 0: 1.5 * 2.0.
    req_valid = 2'b01; res_ready = 2'b11;
    req_x1 = {32'h0, 32'h3FC00000};
    req_x2 = {32'h0, 32'h40000000};
    req_add = 10'd7; req_flag = 2'b01;
    #1 chk("single_rdy", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b00;
    #1 chk("single_busy", 64'(busy), 64'd1);
    step();
    step();
    #1;
    chk("single_vld", 64'(res_valid), 64'b01);
    chk("single_res", 64'({res_y[31:0], res_flag[0], res_add[4:0]}),
        64'({32'h40400000, 1'b1, 5'd7}));
    step();
    idle(3);

    // Both requesters streaming, everything drained immediately.
    gcnt[0] = 0; gcnt[1] = 0;
    repeat (20) begin
      req_valid = 2'b11; res_ready = 2'b11;
      rand_ops();
      step();
    end
    chk("alt_g0", 64'(gcnt[0]), 64'd10);
    chk("alt_g1", 64'(gcnt[1]), 64'd10);
    idle(5);

    // Requester 1 backpressured: credits run out after FDEPTH grants.
    gcnt[0] = 0; gcnt[1] = 0;
    repeat (12) begin
      req_valid = 2'b11; res_ready = 2'b01;
      rand_ops();
      step();
    end
    chk("bp_g1", 64'(gcnt[1]), 64'(FDEPTH));
    chk("bp_all", 64'(gcnt[0] + gcnt[1]), 64'd12);

    // One pop frees one credit, usable only from the following cycle.
    res_ready = 2'b11; rand_ops();
    #1 chk("pop_same", 64'(req_ready), 64'b01);
    step();
    res_ready = 2'b01; rand_ops();
    #1 chk("pop_next", 64'(req_ready), 64'b10);
    step();
    repeat (6) begin rand_ops(); step(); end

    // Full FIFO drained while new requester-1 ops keep arriving.
    repeat (16) begin
      req_valid = 2'b11; res_ready = 2'b11;
      rand_ops();
      step();
    end
    idle(5);

    // Three buffered on requester 0, two in flight on requester 1, then reset mid-cycle.
    res_ready = 2'b00;
    req_valid = 2'b01;
    repeat (3) begin rand_ops(); step(); end
    req_valid = 2'b00;
    repeat (3) step();
    req_valid = 2'b10;
    repeat (2) begin rand_ops(); step(); end
    req_valid = 2'b11; rand_ops();
    #2 rstn = 1'b0;
    #1;
    chk("mid_ready", 64'(req_ready), 64'd0);
    chk("mid_res", 64'({res_valid, busy, res_flag, res_add}), 64'd0);
    chk("mid_fm", {fm_x1, fm_x2}, 64'd0);
    chk("mid_fmtag", 64'({fm_flagin, fm_addin}), 64'd0);
    chk("mid_y", res_y, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    req_valid = 2'b00; res_ready = 2'b00;
    repeat (4) step();
    req_valid = 2'b11;
    #1 chk("post_rst_grant", 64'(req_ready), 64'b01);
    step();
    idle(5);

    // Randomised traffic.
    repeat (400) begin
      req_valid = 2'($urandom);
      res_ready = 2'($urandom);
      rand_ops();
      step();
    end
    idle(10);
    #1 chk("final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
